// File: rtl/rcc_pkg.sv
// Shared RCC definitions: clock-monitor FSM states and parameter legality checks.
package rcc_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ARM     = ST_ARM,
      MEASURE = ST_MEASURE
   } rcc_mon_state_t;

   function automatic bit rcc_sync_delay_ok(input int sync_delay);
      return sync_delay >= 2;
   endfunction

   function automatic bit rcc_mon_params_ok(input int sync_delay, input int window,
                                            input int min_edges, input int max_edges,
                                            input int loss_windows);
      return rcc_sync_delay_ok(sync_delay) && (window >= 4) && (max_edges <= window / 2)
             && (min_edges <= max_edges) && (loss_windows >= 1);
   endfunction

endpackage

// File: rtl/rcc_sync.sv
// Multi-flop synchronizer with synchronous active-high reset, shared across RCC logic.
module rcc_sync
   import rcc_pkg::*;
#(
   parameter int SYNC_DELAY = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_DELAY-1:0] r_sync;

   if (!rcc_sync_delay_ok(SYNC_DELAY)) begin : g_bad_delay
      $error("rcc_sync: SYNC_DELAY must be at least 2");
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DELAY-2:0], d_i};
      end
   end

   assign q_o = r_sync[SYNC_DELAY-1];

endmodule

// File: rtl/rcc_clk_monitor.sv
// Frequency monitor for RCC-generated clocks: counts mon_clk_i rising edges per window.
// Optional irq_o output is enabled by defining RCC_CLK_MON_IRQ_EN.
module rcc_clk_monitor
   import rcc_pkg::*;
#(
   parameter int SYNC_DELAY   = 2,
   parameter int WINDOW       = 64,
   parameter int MIN_EDGES    = 6,
   parameter int MAX_EDGES    = 10,
   parameter int LOSS_WINDOWS = 2,
   parameter int CW           = $clog2(WINDOW + 1)
) (
   input  logic          clk_i,
   input  logic          hw_rst_i,
   input  logic          en_i,
   input  logic          mon_clk_i,
   input  logic          fail_clr_i,
   output logic [CW-1:0] edge_cnt_o,
   output logic          cnt_valid_o,
   output logic          clk_ok_o,
   output logic          clk_fail_o
`ifdef RCC_CLK_MON_IRQ_EN
   ,
   output logic          irq_o
`endif
);

   localparam int WW = $clog2(WINDOW);
   localparam int AW = $clog2(SYNC_DELAY + 1);
   localparam int BW = $clog2(LOSS_WINDOWS + 1);

   if (!rcc_mon_params_ok(SYNC_DELAY, WINDOW, MIN_EDGES, MAX_EDGES, LOSS_WINDOWS)) begin : g_bad_params
      $error("rcc_clk_monitor: illegal parameter set");
   end

   rcc_mon_state_t r_state;
   logic [AW-1:0]  r_arm_cnt;
   logic [WW-1:0]  r_win_cnt;
   logic [CW-1:0]  r_edge_cnt;
   logic [CW-1:0]  r_edge_out;
   logic [BW-1:0]  r_bad_run;
   logic           r_prev;
   logic           r_valid;
   logic           r_ok;
   logic           r_fail;
   logic           r_irq;

   logic           w_sync;
   logic           w_sync_rst;
   logic           w_rise;
   logic           w_win_end;
   logic           w_in_band;
   logic           w_fail_set;
   logic [CW-1:0]  w_cnt_final;
   logic [BW-1:0]  w_bad_next;

   // Synchronizer is held clear while idle so ARM flushes it with fresh samples.
   assign w_sync_rst = hw_rst_i | (r_state == IDLE);

   rcc_sync #(
      .SYNC_DELAY(SYNC_DELAY)
   ) u_sync (
      .clk_i(clk_i),
      .rst_i(w_sync_rst),
      .d_i  (mon_clk_i),
      .q_o  (w_sync)
   );

   always_ff @(posedge clk_i) begin
      if (w_sync_rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_sync;
      end
   end

   assign w_rise      = w_sync & ~r_prev;
   assign w_cnt_final = (w_rise && (r_edge_cnt != {CW{1'b1}})) ? r_edge_cnt + CW'(1) : r_edge_cnt;
   assign w_in_band   = (w_cnt_final >= CW'(MIN_EDGES)) && (w_cnt_final <= CW'(MAX_EDGES));
   assign w_win_end   = en_i && (r_state == MEASURE) && (r_win_cnt == WW'(WINDOW - 1));
   assign w_bad_next  = (r_bad_run == BW'(LOSS_WINDOWS)) ? r_bad_run : r_bad_run + BW'(1);
   assign w_fail_set  = w_win_end && !w_in_band && (w_bad_next == BW'(LOSS_WINDOWS));

   always_ff @(posedge clk_i) begin
      if (hw_rst_i) begin
         r_state    <= IDLE;
         r_arm_cnt  <= '0;
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_edge_out <= '0;
         r_bad_run  <= '0;
         r_valid    <= 1'b0;
         r_ok       <= 1'b0;
      end else if (!en_i) begin
         r_state    <= IDLE;
         r_arm_cnt  <= '0;
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_bad_run  <= '0;
         r_valid    <= 1'b0;
         r_ok       <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_state   <= ARM;
               r_arm_cnt <= '0;
            end
            ARM: begin
               if (r_arm_cnt == AW'(SYNC_DELAY)) begin
                  r_state    <= MEASURE;
                  r_win_cnt  <= '0;
                  r_edge_cnt <= '0;
               end else begin
                  r_arm_cnt <= r_arm_cnt + AW'(1);
               end
            end
            MEASURE: begin
               if (w_win_end) begin
                  // Windows run back to back: the next one starts on the following cycle.
                  r_win_cnt  <= '0;
                  r_edge_cnt <= '0;
                  r_edge_out <= w_cnt_final;
                  r_valid    <= 1'b1;
                  if (w_in_band) begin
                     r_ok      <= 1'b1;
                     r_bad_run <= '0;
                  end else begin
                     r_bad_run <= w_bad_next;
                     if (w_bad_next == BW'(LOSS_WINDOWS)) begin
                        r_ok <= 1'b0;
                     end
                  end
               end else begin
                  r_win_cnt  <= r_win_cnt + WW'(1);
                  r_edge_cnt <= w_cnt_final;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Failure flag survives enable drops; a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i) begin
      if (hw_rst_i) begin
         r_fail <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         r_irq <= w_fail_set & ~r_fail;
         if (w_fail_set) begin
            r_fail <= 1'b1;
         end else if (fail_clr_i) begin
            r_fail <= 1'b0;
         end
      end
   end

   assign edge_cnt_o  = r_edge_out;
   assign cnt_valid_o = r_valid;
   assign clk_ok_o    = r_ok;
   assign clk_fail_o  = r_fail;

`ifdef RCC_CLK_MON_IRQ_EN
   assign irq_o = r_irq;
`else
   logic w_irq_unused;
   assign w_irq_unused = r_irq;
`endif

endmodule

// File: tb/tb_rcc_clk_monitor.sv
// Self-checking bench for rcc_clk_monitor: edge-accurate reference model driven by random clock patterns.
module tb_rcc_clk_monitor;
   import rcc_pkg::*;

   localparam int SD    = 2;
   localparam int W     = 64;
   localparam int MINE  = 6;
   localparam int MAXE  = 10;
   localparam int LOSS  = 2;
   localparam int CW    = $clog2(W + 1);
   localparam int MAXC  = 20000;

   logic          clk_i = 1'b0;
   logic          hw_rst_i;
   logic          en_i;
   logic          mon_clk_i;
   logic          fail_clr_i;
   logic [CW-1:0] edge_cnt_o;
   logic          cnt_valid_o;
   logic          clk_ok_o;
   logic          clk_fail_o;
   logic          irq_mon;

   rcc_clk_monitor #(
      .SYNC_DELAY(SD), .WINDOW(W), .MIN_EDGES(MINE), .MAX_EDGES(MAXE), .LOSS_WINDOWS(LOSS)
   ) dut (
      .clk_i      (clk_i),
      .hw_rst_i   (hw_rst_i),
      .en_i       (en_i),
      .mon_clk_i  (mon_clk_i),
      .fail_clr_i (fail_clr_i),
      .edge_cnt_o (edge_cnt_o),
      .cnt_valid_o(cnt_valid_o),
      .clk_ok_o   (clk_ok_o),
      .clk_fail_o (clk_fail_o)
`ifdef RCC_CLK_MON_IRQ_EN
      ,
      .irq_o      (irq_mon)
`endif
   );

`ifndef RCC_CLK_MON_IRQ_EN
   assign irq_mon = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Stimulus generator state and the per-edge record of mon_clk rising edges as seen by clk_i.
   int cyc = 0;
   bit rise [0:MAXC];
   int half = 0;
   bit stuck_val = 1'b0;

   // Reference model state.
   int m_bad = 0;
   bit m_ok = 1'b0;
   bit m_fail = 1'b0;
   int m_cnt = 0;
   int e_next = 0;
   int clr_edge = -1;
   int chg_edge = -1;
   int chg_half = 0;

   initial begin : gen
      int ph;
      int last_half;
      bit prev_s;
      ph = 0;
      last_half = 0;
      prev_s = 1'b0;
      mon_clk_i = 1'b0;
      forever begin
         @(posedge clk_i);
         cyc++;
         if (cyc <= MAXC) rise[cyc] = mon_clk_i & ~prev_s;
         prev_s = mon_clk_i;
         #1;
         if (half != last_half) begin
            last_half = half;
            ph = 0;
            if (half == 0) mon_clk_i = stuck_val;
         end else if (half == 0) begin
            mon_clk_i = stuck_val;
         end else if (ph == half - 1) begin
            ph = 0;
            mon_clk_i = ~mon_clk_i;
         end else begin
            ph++;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Runs up to the next window end, then checks the window result against the model.
   task automatic run_win();
      bit stray;
      int guard;
      int cnt;
      bit set;
      bit old_fail;
      bit exp_irq;
      stray = 1'b0;
      guard = 0;
      while (cyc != e_next && guard <= W + SD + 8) begin
         @(negedge clk_i);
         guard++;
         fail_clr_i = (cyc + 1 == clr_edge);
         if (cyc == chg_edge) half = chg_half;
         if (cyc == clr_edge && cyc != e_next) m_fail = 1'b0;
         if (cyc != e_next && (cnt_valid_o || irq_mon)) stray = 1'b1;
      end
      checks++;
      if (cyc != e_next) begin
         errors++;
         $display("FAIL win_timeout: at edge %0d, required window end at edge %0d", cyc, e_next);
         return;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL stray_pulse: valid/irq seen before window end %0d, required none", e_next);
      end
      cnt = 0;
      for (int j = e_next - SD - W + 1; j <= e_next - SD; j++) cnt += rise[j];
      if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
      old_fail = m_fail;
      set = 1'b0;
      if (cnt >= MINE && cnt <= MAXE) begin
         m_ok = 1'b1;
         m_bad = 0;
      end else begin
         m_bad = (m_bad < LOSS) ? m_bad + 1 : LOSS;
         if (m_bad == LOSS) begin
            m_ok = 1'b0;
            set = 1'b1;
         end
      end
      if (set) m_fail = 1'b1;
      else if (clr_edge == e_next) m_fail = 1'b0;
      exp_irq = set && !old_fail;
      m_cnt = cnt;
      checks++;
      if (cnt_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL cnt_valid: edge %0d got %b exp 1", cyc, cnt_valid_o);
      end
      checks++;
      if (edge_cnt_o !== CW'(cnt)) begin
         errors++;
         $display("FAIL edge_cnt: edge %0d got %0d exp %0d", cyc, edge_cnt_o, cnt);
      end
      checks++;
      if (clk_ok_o !== m_ok) begin
         errors++;
         $display("FAIL clk_ok: edge %0d got %b exp %b", cyc, clk_ok_o, m_ok);
      end
      checks++;
      if (clk_fail_o !== m_fail) begin
         errors++;
         $display("FAIL clk_fail: edge %0d got %b exp %b", cyc, clk_fail_o, m_fail);
      end
`ifdef RCC_CLK_MON_IRQ_EN
      checks++;
      if (irq_mon !== exp_irq) begin
         errors++;
         $display("FAIL irq: edge %0d got %b exp %b", cyc, irq_mon, exp_irq);
      end
`else
      if (exp_irq) m_cnt = cnt;
`endif
      e_next += W;
   endtask

   task automatic do_enable();
      @(negedge clk_i);
      en_i = 1'b1;
      @(negedge clk_i);
      e_next = cyc + SD + 1 + W;
      m_ok = 1'b0;
      m_bad = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({cnt_valid_o, edge_cnt_o, clk_ok_o, clk_fail_o} !== '0) begin
         errors++;
         $display("FAIL %s: valid=%b cnt=%0d ok=%b fail=%b exp all 0", tag, cnt_valid_o,
                  edge_cnt_o, clk_ok_o, clk_fail_o);
      end
`ifdef RCC_CLK_MON_IRQ_EN
      checks++;
      if (irq_mon !== 1'b0) begin
         errors++;
         $display("FAIL %s_irq: got %b exp 0", tag, irq_mon);
      end
`endif
      checks++;
      if (dut.r_state !== IDLE) begin
         errors++;
         $display("FAIL %s_state: got %0d exp %0d", tag, dut.r_state, IDLE);
      end
   endtask

   task automatic test_reset();
      hw_rst_i = 1'b1;
      en_i = 1'b0;
      fail_clr_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check_idle_outputs("reset");
      hw_rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_in_band();
      half = 4;
      do_enable();
      for (int k = 0; k < 3; k++) run_win();
      checks++;
      if (edge_cnt_o !== CW'(8) || clk_ok_o !== 1'b1) begin
         errors++;
         $display("FAIL in_band_div8: cnt=%0d ok=%b exp cnt=8 ok=1", edge_cnt_o, clk_ok_o);
      end
   endtask

   task automatic test_fast();
      half = 2;
      for (int k = 0; k < 2; k++) run_win();
      checks++;
      if (clk_fail_o !== 1'b1 || clk_ok_o !== 1'b0) begin
         errors++;
         $display("FAIL fast_fail: fail=%b ok=%b exp fail=1 ok=0", clk_fail_o, clk_ok_o);
      end
      half = 4;
      for (int k = 0; k < 2; k++) run_win();
      checks++;
      if (clk_fail_o !== 1'b1 || clk_ok_o !== 1'b1) begin
         errors++;
         $display("FAIL fast_restore: fail=%b ok=%b exp fail=1 ok=1", clk_fail_o, clk_ok_o);
      end
   endtask

   task automatic test_stuck();
      stuck_val = 1'b0;
      half = 0;
      clr_edge = e_next - 20;
      run_win();
      clr_edge = -1;
      run_win();
      checks++;
      if (clk_fail_o !== 1'b1 || edge_cnt_o !== '0) begin
         errors++;
         $display("FAIL stuck_fail: fail=%b cnt=%0d exp fail=1 cnt=0", clk_fail_o, edge_cnt_o);
      end
   endtask

   task automatic test_clear_collision();
      clr_edge = e_next;
      run_win();
      clr_edge = -1;
      fail_clr_i = 1'b1;
      @(negedge clk_i);
      fail_clr_i = 1'b0;
      m_fail = 1'b0;
      checks++;
      if (clk_fail_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_after_collision: got %b exp 0", clk_fail_o);
      end
      half = 4;
      run_win();
   endtask

   task automatic test_enable_drop();
      bit stray;
      run_win();
      repeat (29) @(negedge clk_i);
      en_i = 1'b0;
      @(negedge clk_i);
      m_ok = 1'b0;
      m_bad = 0;
      checks++;
      if (cnt_valid_o !== 1'b0 || clk_ok_o !== 1'b0 || edge_cnt_o !== CW'(m_cnt) || clk_fail_o !== m_fail) begin
         errors++;
         $display("FAIL en_drop: valid=%b ok=%b cnt=%0d fail=%b exp 0 0 %0d %b", cnt_valid_o,
                  clk_ok_o, edge_cnt_o, clk_fail_o, m_cnt, m_fail);
      end
      stray = 1'b0;
      repeat (50) begin
         @(negedge clk_i);
         if (cnt_valid_o) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL en_drop_valid: pulse while disabled, exp none");
      end
      do_enable();
      run_win();
      run_win();
   endtask

   task automatic test_reset_mid();
      half = 0;
      stuck_val = 1'b1;
      run_win();
      run_win();
      repeat (20) @(negedge clk_i);
      hw_rst_i = 1'b1;
      @(negedge clk_i);
      check_idle_outputs("rst_mid");
      hw_rst_i = 1'b0;
      en_i = 1'b0;
      m_ok = 1'b0;
      m_bad = 0;
      m_fail = 1'b0;
      m_cnt = 0;
      @(negedge clk_i);
   endtask

   task automatic test_random();
      int halves [7] = '{0, 2, 3, 4, 5, 6, 8};
      half = 4;
      do_enable();
      for (int r = 0; r < 12; r++) begin
         chg_half = halves[$urandom_range(0, 6)];
         stuck_val = 1'($urandom_range(0, 1));
         chg_edge = e_next - int'($urandom_range(1, W - 1));
         clr_edge = ($urandom_range(0, 2) == 0) ? e_next - int'($urandom_range(0, W - 2)) : -1;
         run_win();
      end
      chg_edge = -1;
      clr_edge = -1;
   endtask

   initial begin
      hw_rst_i = 1'b1;
      en_i = 1'b0;
      fail_clr_i = 1'b0;
      test_reset();
      test_in_band();
      test_fast();
      test_stuck();
      test_clear_collision();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
